gravity_ctrl: RTL and testbench
===============================

// Module: gravity_ctrl
// PURPOSE
//  Sequences piece gravity for the Tetris core. Restarts the fall timer, turns its
//  timeout or a soft-drop cadence into one-step drop requests to the board logic, and
//  runs lock delay when a drop is blocked. Tracks lines cleared and drives the level
//  input of the fall timer. Sits between fall timer, key decoder and board/piece FSM.
// PARAMETERS
//  LOCK_DELAY      50_000_000  cycles a blocked piece waits before lock (0.5 s @100MHz)
//  SOFT_PERIOD     5_000_000   cycles between soft-drop steps (50 ms)
//  LINES_PER_LEVEL 10          cleared lines per level increment
//  MAX_LEVEL       1           level saturation value (fits `LEVEL_LEN)
// PORTS
//  clk           in  1           100 MHz system clock
//  rst           in  1           synchronous, active-high reset
//  start         in  1           pulse: new piece spawned, begin gravity
//  timeout       in  1           fall timer expired (level signal, held until timer_rst)
//  soft_drop     in  1           debounced soft-drop key, level
//  mv_ack        in  1           board accepted drop_req this cycle
//  mv_blocked    in  1           valid with mv_ack: piece could not move down
//  lock_ack      in  1           board finished locking the piece
//  clear_valid   in  1           pulse: lines_cleared valid
//  lines_cleared in  3           lines cleared by last lock (0..4)
//  timer_rst     out 1           1-cycle pulse restarting fall timer
//  drop_req      out 1           request one-row drop; held until mv_ack
//  lock_req      out 1           request lock; held until lock_ack
//  level         out `LEVEL_LEN  current level to fall timer
//  busy          out 1           high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; level 0; line counter 0; delay counters 0.
//  States: IDLE, WAIT, REQ, LOCKW, LOCK.
//  IDLE : start -> WAIT, timer_rst=1 on transition cycle.
//  WAIT : timeout -> REQ. soft_drop high: soft counter increments each cycle; at
//         SOFT_PERIOD-1 -> REQ. Soft counter clears when soft_drop low or leaving WAIT.
//         timeout and soft expiry same cycle -> single REQ (one drop only).
//  REQ  : drop_req=1 (registered, asserted first cycle in REQ). On mv_ack:
//         !mv_blocked -> WAIT, timer_rst pulse; mv_blocked -> LOCKW, lock counter=0.
//  LOCKW: lock counter increments; at LOCK_DELAY-1 -> LOCK. timeout or soft step here
//         -> REQ (retry drop; if it now succeeds, lock delay abandoned). Counter is NOT
//         reset by retries that return blocked (no infinite stall).
//  LOCK : lock_req=1 until lock_ack -> IDLE. start ignored outside IDLE.
//  Handshake: mv_ack/lock_ack outside REQ/LOCK are ignored; req drops the cycle after ack.
//  Level: clear_valid adds lines_cleared to 8-bit saturating line counter (any state);
//   level = min(lines/LINES_PER_LEVEL, MAX_LEVEL), registered, updates 1 cycle later.
//  rst mid-operation: returns to IDLE next edge, drop_req/lock_req drop immediately.
// CONFIGURATION
//  HARD_DROP_EN defined: adds input hard_drop (pulse). In WAIT/LOCKW, hard_drop -> REQ
//   and REQ repeats back-to-back (no WAIT, no timer_rst) until mv_blocked, then goes
//   directly to LOCK (lock delay skipped). Undefined: no port, hard drop absent.
// TESTING
//  rst, start, timeout@100 cycles -> timer_rst@start+1, drop_req until mv_ack, timer_rst.
//  soft_drop held, SOFT_PERIOD=8 -> drop_req every 8 WAIT cycles, no timeout needed.
//  mv_ack+mv_blocked, no further events, LOCK_DELAY=16 -> lock_req 16 cycles after ack.
//  blocked then timeout in LOCKW with unblocked ack -> WAIT, lock_req never asserted.
//  clear_valid x3 with 4,4,2 lines, LINES_PER_LEVEL=10 -> level 0,0,1; further clears stay 1.
//  HARD_DROP_EN: hard_drop with 3 free rows -> 4 consecutive drop_req, 4th blocked, lock_req.

Source files
------------

// File: rtl/gravity_ctrl.sv
// Piece gravity sequencer: fall-timer restarts, drop requests, lock delay and level tracking.
// Optional HARD_DROP_EN adds a hard_drop input; `LEVEL_LEN sets the level width (default 4).
`ifndef LEVEL_LEN
`define LEVEL_LEN 4
`endif

module gravity_ctrl #(
  parameter int unsigned LOCK_DELAY      = 50_000_000,
  parameter int unsigned SOFT_PERIOD     = 5_000_000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  timeout,
  input  logic                  soft_drop,
  input  logic                  mv_ack,
  input  logic                  mv_blocked,
  input  logic                  lock_ack,
  input  logic                  clear_valid,
  input  logic [2:0]            lines_cleared,
`ifdef HARD_DROP_EN
  input  logic                  hard_drop,
`endif
  output logic                  timer_rst,
  output logic                  drop_req,
  output logic                  lock_req,
  output logic [`LEVEL_LEN-1:0] level,
  output logic                  busy
);
  localparam int unsigned LOCK_W  = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam int unsigned SOFT_W  = (SOFT_PERIOD > 1) ? $clog2(SOFT_PERIOD) : 1;
  localparam int unsigned LINE_W  = 8;
  localparam int unsigned LEVEL_W = `LEVEL_LEN;

  typedef enum logic [2:0] {IDLE, WAIT, REQ, LOCKW, LOCK} state_t;

  state_t              state, state_n;
  logic [LOCK_W-1:0]   lock_cnt, lock_cnt_n;
  logic [SOFT_W-1:0]   soft_cnt, soft_cnt_n;
  logic                retry, retry_n;
  logic                hard, hard_n;
  logic                timer_rst_n;
  logic                soft_step, lock_done, hard_evt;
  logic [LINE_W-1:0]   lines, lines_n;
  logic [LINE_W:0]     lines_sum;
  logic [31:0]         lvl_q;
  logic [LEVEL_W-1:0]  level_n;

`ifdef HARD_DROP_EN
  assign hard_evt = hard_drop;
`else
  assign hard_evt = 1'b0;
`endif

  // Next-state logic; retry marks a drop issued from lock wait so its counter survives.
  always_comb begin
    state_n     = state;
    lock_cnt_n  = lock_cnt;
    soft_cnt_n  = '0;
    retry_n     = retry;
    hard_n      = hard;
    timer_rst_n = 1'b0;
    soft_step   = 1'b0;
    lock_done   = (lock_cnt == LOCK_W'(LOCK_DELAY - 1));

    if ((state == WAIT || state == LOCKW) && soft_drop) begin
      if (soft_cnt == SOFT_W'(SOFT_PERIOD - 1)) soft_step = 1'b1;
      else soft_cnt_n = soft_cnt + SOFT_W'(1);
    end

    case (state)
      IDLE: if (start) begin
        state_n     = WAIT;
        timer_rst_n = 1'b1;
      end
      WAIT: if (hard_evt) begin
        state_n = REQ;
        hard_n  = 1'b1;
        retry_n = 1'b0;
      end else if (timeout || soft_step) begin
        state_n = REQ;
        hard_n  = 1'b0;
        retry_n = 1'b0;
      end
      REQ: if (mv_ack) begin
        if (!mv_blocked) begin
          if (!hard) begin
            state_n     = WAIT;
            timer_rst_n = 1'b1;
            retry_n     = 1'b0;
          end
        end else if (hard) begin
          state_n = LOCK;
          hard_n  = 1'b0;
        end else begin
          state_n = LOCKW;
          if (!retry) lock_cnt_n = '0;
          retry_n = 1'b0;
        end
      end
      LOCKW: begin
        if (!lock_done) lock_cnt_n = lock_cnt + LOCK_W'(1);
        if (lock_done) begin
          state_n = LOCK;
        end else if (hard_evt) begin
          state_n = REQ;
          hard_n  = 1'b1;
        end else if (timeout || soft_step) begin
          state_n = REQ;
          retry_n = 1'b1;
        end
      end
      LOCK: if (lock_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n != WAIT && state_n != LOCKW) soft_cnt_n = '0;
  end

  // Saturating line counter and level derived from the updated count.
  always_comb begin
    lines_sum = {1'b0, lines} + (LINE_W + 1)'(lines_cleared);
    lines_n   = lines;
    if (clear_valid) lines_n = lines_sum[LINE_W] ? {LINE_W{1'b1}} : lines_sum[LINE_W-1:0];
    lvl_q     = 32'(lines_n) / 32'(LINES_PER_LEVEL);
    level_n   = (lvl_q > 32'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : LEVEL_W'(lvl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      soft_cnt  <= '0;
      retry     <= 1'b0;
      hard      <= 1'b0;
      lines     <= '0;
      level     <= '0;
      timer_rst <= 1'b0;
      drop_req  <= 1'b0;
      lock_req  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_cnt_n;
      soft_cnt  <= soft_cnt_n;
      retry     <= retry_n;
      hard      <= hard_n;
      lines     <= lines_n;
      level     <= level_n;
      timer_rst <= timer_rst_n;
      drop_req  <= (state_n == REQ);
      lock_req  <= (state_n == LOCK);
      busy      <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_gravity_ctrl.sv
// Self-checking bench for gravity_ctrl: directed sequences with randomized timing and a
// cycle-count / line-sum reference model.
module tb_gravity_ctrl;
  localparam int unsigned LOCK_DELAY = 16;
  localparam int unsigned SOFT_PERIOD = 8;
  localparam int unsigned LPL = 10;
  localparam int unsigned MAX_LEVEL = 1;

  logic clk = 1'b0;
  logic rst, start, timeout, soft_drop, mv_ack, mv_blocked, lock_ack, clear_valid;
  logic [2:0] lines_cleared;
`ifdef HARD_DROP_EN
  logic hard_drop;
`endif
  logic timer_rst, drop_req, lock_req, busy;
  logic [`LEVEL_LEN-1:0] level;

  int checks = 0;
  int failures = 0;
  int lines_model, lockw_seen, ack_wait, r1, r2, nr, retries_done, budget, acks, v;
  bit done;

  always #5 clk = ~clk;

  gravity_ctrl #(
    .LOCK_DELAY(LOCK_DELAY), .SOFT_PERIOD(SOFT_PERIOD),
    .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .timeout(timeout), .soft_drop(soft_drop),
    .mv_ack(mv_ack), .mv_blocked(mv_blocked), .lock_ack(lock_ack),
    .clear_valid(clear_valid), .lines_cleared(lines_cleared),
`ifdef HARD_DROP_EN
    .hard_drop(hard_drop),
`endif
    .timer_rst(timer_rst), .drop_req(drop_req), .lock_req(lock_req),
    .level(level), .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_level(input int lines);
    int l;
    l = lines / LPL;
    return (l > MAX_LEVEL) ? MAX_LEVEL : l;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; timeout = 1'b0; soft_drop = 1'b0; mv_ack = 1'b0;
    mv_blocked = 1'b0; lock_ack = 1'b0; clear_valid = 1'b0; lines_cleared = 3'd0;
`ifdef HARD_DROP_EN
    hard_drop = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    lines_model = 0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
    chk("start_timer_rst", 32'(timer_rst), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_no_drop", 32'(drop_req), 0);
    step();
    chk("start_timer_rst_pulse", 32'(timer_rst), 0);
  endtask

  task automatic lock_release();
    start = 1'b1; step(); start = 1'b0;
    chk("start_ignored_in_lock", 32'(timer_rst), 0);
    chk("lock_req_held", 32'(lock_req), 1);
    repeat ($urandom_range(0, 3)) begin
      step(); chk("lock_req_wait", 32'(lock_req), 1);
    end
    lock_ack = 1'b1; step(); lock_ack = 1'b0;
    chk("lock_req_drop", 32'(lock_req), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    do_reset();
    chk("rst_timer_rst", 32'(timer_rst), 0);
    chk("rst_drop_req", 32'(drop_req), 0);
    chk("rst_lock_req", 32'(lock_req), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);

    // Timeout-driven drops; stray acks while waiting must be ignored.
    do_start();
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(1, 20)) begin
        mv_ack = 1'($urandom); mv_blocked = 1'($urandom);
        step();
        chk("wait_no_drop", 32'(drop_req), 0);
        chk("wait_no_timer_rst", 32'(timer_rst), 0);
        chk("wait_no_lock", 32'(lock_req), 0);
      end
      mv_ack = 1'b0; mv_blocked = 1'b0;
      timeout = 1'b1; step();
      chk("to_drop_req", 32'(drop_req), 1);
      repeat ($urandom_range(0, 4)) begin
        step(); chk("to_drop_held", 32'(drop_req), 1);
      end
      mv_ack = 1'b1; step(); mv_ack = 1'b0;
      chk("to_drop_cleared", 32'(drop_req), 0);
      chk("to_timer_rst", 32'(timer_rst), 1);
      timeout = 1'b0; step();
      chk("to_timer_rst_pulse", 32'(timer_rst), 0);
    end

    // Soft drop cadence: a request every SOFT_PERIOD cycles spent waiting.
    soft_drop = 1'b1;
    for (int it = 0; it < 3; it++) begin
      repeat (SOFT_PERIOD - 1) begin
        step(); chk("soft_early", 32'(drop_req), 0);
      end
      step(); chk("soft_drop_req", 32'(drop_req), 1);
      repeat ($urandom_range(0, 3)) begin
        step(); chk("soft_drop_held", 32'(drop_req), 1);
      end
      mv_ack = 1'b1; step(); mv_ack = 1'b0;
      chk("soft_ack_clear", 32'(drop_req), 0);
      chk("soft_timer_rst", 32'(timer_rst), 1);
    end
    soft_drop = 1'b0;

    // Lock delay with 0, 1 or 2 blocked retries; time spent in lock wait is cumulative.
    for (nr = 0; nr < 3; nr++) begin
      timeout = 1'b1; step(); timeout = 1'b0;
      chk("lk_drop_req", 32'(drop_req), 1);
      mv_ack = 1'b1; mv_blocked = 1'b1;
      r1 = $urandom_range(2, 6); r2 = $urandom_range(8, 13);
      lockw_seen = 0; retries_done = 0; ack_wait = 0; done = 1'b0; budget = 200;
      while (!done && budget > 0) begin
        step(); budget--;
        mv_ack = 1'b0; mv_blocked = 1'b0; timeout = 1'b0;
        if (lock_req) begin
          done = 1'b1;
        end else if (drop_req) begin
          if (ack_wait == 0) begin mv_ack = 1'b1; mv_blocked = 1'b1; end
          else ack_wait--;
        end else begin
          lockw_seen++;
          chk("lk_busy", 32'(busy), 1);
          chk("lk_no_timer_rst", 32'(timer_rst), 0);
          if (retries_done < nr && lockw_seen == ((retries_done == 0) ? r1 : r2)) begin
            timeout = 1'b1; retries_done++; ack_wait = $urandom_range(0, 2);
          end else if ($urandom_range(0, 3) == 0) begin
            mv_ack = 1'b1;
          end
        end
      end
      mv_ack = 1'b0; timeout = 1'b0;
      chk("lk_reached", 32'(done), 1);
      chk("lk_delay_cycles", 32'(lockw_seen), LOCK_DELAY);
      chk("lk_no_drop", 32'(drop_req), 0);
      lock_release();
      do_start();
    end

    // Blocked, then a retry that succeeds: lock delay abandoned.
    timeout = 1'b1; step(); timeout = 1'b0;
    chk("rt_drop_req", 32'(drop_req), 1);
    mv_ack = 1'b1; mv_blocked = 1'b1; step(); mv_ack = 1'b0; mv_blocked = 1'b0;
    chk("rt_lockw", 32'(drop_req), 0);
    repeat ($urandom_range(1, 10)) step();
    timeout = 1'b1; step(); timeout = 1'b0;
    chk("rt_retry_req", 32'(drop_req), 1);
    mv_ack = 1'b1; step(); mv_ack = 1'b0;
    chk("rt_timer_rst", 32'(timer_rst), 1);
    done = 1'b0;
    repeat (40) begin
      step();
      if (lock_req || drop_req) done = 1'b1;
    end
    chk("rt_never_locked", 32'(done), 0);
    chk("rt_still_busy", 32'(busy), 1);

    // Reset in the middle of a drop request.
    timeout = 1'b1; step();
    chk("mid_drop_req", 32'(drop_req), 1);
    rst = 1'b1; step(); rst = 1'b0; timeout = 1'b0;
    chk("mid_rst_drop", 32'(drop_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);

    // Level from cleared lines, updated during gameplay too.
    do_reset();
    do_start();
    for (int i = 0; i < 15; i++) begin
      case (i)
        0: v = 4; 1: v = 4; 2: v = 2;
        default: v = $urandom_range(0, 4);
      endcase
      clear_valid = 1'b1; lines_cleared = 3'(v); step();
      clear_valid = 1'b0; lines_cleared = 3'($urandom_range(1, 4));
      lines_model = (lines_model + v > 255) ? 255 : lines_model + v;
      chk("lvl_after_clear", 32'(level), 32'(exp_level(lines_model)));
      repeat ($urandom_range(0, 2)) step();
      chk("lvl_no_clear", 32'(level), 32'(exp_level(lines_model)));
    end
    do_reset();
    chk("lvl_rst", 32'(level), 0);
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 9 : (i == 1) ? 0 : 1;
      if (v > 4) begin
        clear_valid = 1'b1; lines_cleared = 3'd4; step();
        lines_cleared = 3'(v - 4); step();
      end else begin
        clear_valid = 1'b1; lines_cleared = 3'(v); step();
      end
      clear_valid = 1'b0;
      lines_model = lines_model + v;
      chk("lvl_boundary", 32'(level), 32'(exp_level(lines_model)));
    end

`ifdef HARD_DROP_EN
    // Hard drop with three free rows: four back-to-back requests then lock.
    do_reset();
    do_start();
    hard_drop = 1'b1; step(); hard_drop = 1'b0;
    acks = 0; budget = 0;
    while (!lock_req && budget < 20) begin
      chk("hd_drop_held", 32'(drop_req), 1);
      acks++; mv_ack = 1'b1; mv_blocked = (acks >= 4);
      step(); budget++;
      mv_ack = 1'b0; mv_blocked = 1'b0;
      chk("hd_no_timer_rst", 32'(timer_rst), 0);
    end
    chk("hd_acks", 32'(acks), 4);
    chk("hd_lock_req", 32'(lock_req), 1);
    chk("hd_drop_cleared", 32'(drop_req), 0);
    lock_release();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
